// File: rtl/compositor_pkg.sv
// compositor_pkg: screen-mode encodings, default pixel width and counter-width helper for layer_compositor.
package compositor_pkg;
  localparam int RGB_W_DEF = 12;
  typedef enum logic [1:0] {
    MODE_START = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_OVER  = 2'd2
  } mode_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/layer_prio_enc.sv
// layer_prio_enc: picks the lowest-index enabled, non-transparent layer colour.
module layer_prio_enc #(
  parameter int N_LAYERS = 8,
  parameter int RGB_W = 12,
  parameter logic [RGB_W-1:0] TRANSP_KEY = '0
) (
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  output logic                      hit,
  output logic [RGB_W-1:0]          rgb
);
  logic [N_LAYERS:0] h;
  logic [RGB_W-1:0] c [N_LAYERS+1];
  assign h[N_LAYERS] = 1'b0;
  assign c[N_LAYERS] = '0;
  // Chain runs from the top layer down so index 0 is resolved last and wins.
  for (genvar i = 0; i < N_LAYERS; i++) begin : g_l
    logic [RGB_W-1:0] px;
    logic t;
    assign px = layer_rgb[i*RGB_W +: RGB_W];
    assign t = layer_en[i] && px != TRANSP_KEY;
    assign h[i] = t | h[i+1];
    assign c[i] = t ? px : c[i+1];
  end
  assign hit = h[0];
  assign rgb = c[0];
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: N-layer pixel compositor with 2-stage pipeline and START/PLAY/OVER screen FSM.
// Optional hit flash (inverted PLAY pixel) when LAYER_COMPOSITOR_FLASH_EN is defined.
module layer_compositor import compositor_pkg::*; #(
  parameter int N_LAYERS = 8,
  parameter int RGB_W = RGB_W_DEF,
  parameter logic [RGB_W-1:0] TRANSP_KEY = '0,
  parameter int BLINK_FRAMES = 32,
  parameter int OVER_FRAMES = 180,
  parameter int FLASH_FRAMES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic [RGB_W-1:0]          start_rgb,
  input  logic [RGB_W-1:0]          end_rgb,
  input  logic                      start_req,
  input  logic                      game_over,
  input  logic                      hit_pulse,
  output logic [RGB_W-1:0]          rgb_out,
  output logic                      rgb_valid,
  output logic [1:0]                mode
);
  localparam int BW = idx_w(BLINK_FRAMES);
  localparam int OW = idx_w(OVER_FRAMES);
  mode_e mode_q, mode_d;
  logic start_pend_q, start_pend_d, over_pend_q, over_pend_d, phase_q, phase_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [OW-1:0] over_cnt_q, over_cnt_d;
  logic hit, blink_wrap, over_done, flash_inv;
  logic [RGB_W-1:0] win_rgb, s1_win_d, s1_win_q, s1_start_q, s1_end_q, s1_bg_q, pix, rgb_d, rgb_q;
  logic s1_valid_q, rgb_valid_q;
  layer_prio_enc #(.N_LAYERS(N_LAYERS), .RGB_W(RGB_W), .TRANSP_KEY(TRANSP_KEY)) u_prio (
    .layer_en (layer_en),
    .layer_rgb(layer_rgb),
    .hit      (hit),
    .rgb      (win_rgb)
  );
  assign blink_wrap = blink_cnt_q == BW'(BLINK_FRAMES - 1);
  assign over_done = over_cnt_q == OW'(OVER_FRAMES - 1);
  // Flags sample only this frame's requests; a pulse on frame_start lands in the next frame.
  always_comb begin
    start_pend_d = frame_start ? start_req : start_pend_q | start_req;
    over_pend_d = frame_start ? game_over : over_pend_q | game_over;
    mode_d = mode_q;
    blink_cnt_d = blink_cnt_q;
    phase_d = phase_q;
    over_cnt_d = over_cnt_q;
    if (frame_start)
      case (mode_q)
        MODE_START:
          if (start_pend_q) mode_d = MODE_PLAY;
          else begin
            blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
            phase_d = phase_q ^ blink_wrap;
          end
        MODE_PLAY:
          if (over_pend_q) begin
            mode_d = MODE_OVER;
            over_cnt_d = '0;
          end
        default:
          if (start_pend_q || over_done) begin
            mode_d = MODE_START;
            blink_cnt_d = '0;
            phase_d = 1'b0;
          end else over_cnt_d = over_cnt_q + 1'b1;
      endcase
    s1_win_d = hit ? win_rgb : bg_rgb;
    pix = mode_q == MODE_PLAY ? (flash_inv ? ~s1_win_q : s1_win_q) :
          mode_q == MODE_OVER ? s1_end_q : phase_q ? s1_bg_q : s1_start_q;
    rgb_d = s1_valid_q ? pix : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= MODE_START;
      start_pend_q <= 1'b0;
      over_pend_q <= 1'b0;
      phase_q <= 1'b0;
      blink_cnt_q <= '0;
      over_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_win_q <= '0;
      s1_start_q <= '0;
      s1_end_q <= '0;
      s1_bg_q <= '0;
      rgb_q <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      start_pend_q <= start_pend_d;
      over_pend_q <= over_pend_d;
      phase_q <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      over_cnt_q <= over_cnt_d;
      s1_valid_q <= pix_valid;
      s1_win_q <= s1_win_d;
      s1_start_q <= start_rgb;
      s1_end_q <= end_rgb;
      s1_bg_q <= bg_rgb;
      rgb_q <= rgb_d;
      rgb_valid_q <= s1_valid_q;
    end
`ifdef LAYER_COMPOSITOR_FLASH_EN
  localparam int FW = idx_w(FLASH_FRAMES + 1) < 2 ? 2 : idx_w(FLASH_FRAMES + 1);
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  always_comb
    flash_cnt_d = mode_d != MODE_PLAY ? '0 :
                  (hit_pulse && mode_q == MODE_PLAY) ? FW'(FLASH_FRAMES) :
                  (frame_start && flash_cnt_q != '0) ? flash_cnt_q - 1'b1 : flash_cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) flash_cnt_q <= '0;
    else flash_cnt_q <= flash_cnt_d;
  assign flash_inv = flash_cnt_q != '0 && flash_cnt_q[1];
`else
  logic unused_hit;
  assign unused_hit = hit_pulse;
  assign flash_inv = 1'b0;
`endif
  assign rgb_out = rgb_q;
  assign rgb_valid = rgb_valid_q;
  assign mode = mode_q;
endmodule
